// File: rtl/mem_stage_if.sv
// mem_stage_if: handshake and bus signals around the MEM pipeline stage.
// The master modport is the stage itself. The slave modport is the
// surrounding pipeline: the EX/WB neighbours and the data SRAM.
interface mem_stage_if #(
  parameter int EX_MEM_BUS_W = 108,
  parameter int MEM_WB_BUS_W = 102
);
  logic                    ex_mem_valid;
  logic                    mem_allowin;
  logic [EX_MEM_BUS_W-1:0] ex_mem_bus;
  logic [31:0]             data_sram_rdata;
  logic                    mem_wb_valid;
  logic                    wb_allowin;
  logic [MEM_WB_BUS_W-1:0] mem_wb_bus;
  logic [37:0]             mem_id_bus;
  logic                    mem_ale;

  modport master (
    input  ex_mem_valid, ex_mem_bus, data_sram_rdata, wb_allowin,
    output mem_allowin, mem_wb_valid, mem_wb_bus, mem_id_bus, mem_ale
  );

  modport slave (
    output ex_mem_valid, ex_mem_bus, data_sram_rdata, wb_allowin,
    input  mem_allowin, mem_wb_valid, mem_wb_bus, mem_id_bus, mem_ale
  );
endinterface

// File: rtl/mem_stage.sv
// mem_stage: memory-access pipeline stage.
// - Latches the EX->MEM bus.
// - Extracts and extends load data from the data SRAM read port.
// - Forwards the result to WB and publishes a bypass bus to ID.
// The SRAM read data is only valid in the first MEM cycle. While WB stalls,
// a hold register keeps that first-cycle value.
// Optional macro MEM_ALIGN_CHECK_EN enables misaligned-load detection.
// When it is enabled, a misaligned load raises mem_ale and loses its
// register write.
module mem_stage #(
  parameter int EX_MEM_BUS_W = 108,
  parameter int MEM_WB_BUS_W = 102
) (
  input logic         clk,
  input logic         resetn,
  mem_stage_if.master mif
);

  logic                    mem_valid_p0;
  logic                    hold_valid_p0;
  logic [31:0]             rdata_hold_p0;
  logic [EX_MEM_BUS_W-1:0] bus_p0;

  logic                    allowin;
  logic                    accept;
  logic                    leave;

  logic                    gr_we;
  logic                    res_from_mem;
  logic [2:0]              mem_type;
  logic [1:0]              addr_low2;
  logic [4:0]              dest;
  logic [31:0]             pc;
  logic [31:0]             inst;
  logic [31:0]             result;

  logic [31:0]             raw;
  logic [31:0]             load_data;
  logic [31:0]             final_result;
  logic                    ale;
  logic                    wr_en;
  logic [MEM_WB_BUS_W-1:0] wb_bus;

  // Select the byte or half addressed by addr_low2, then sign- or zero-extend it.
  function automatic logic [31:0] load_extract(input logic [31:0] rd,
                                               input logic [2:0]  mtype,
                                               input logic [1:0]  a);
    logic signed [7:0]  byte_s;
    logic signed [15:0] half_s;
    logic [31:0]        ld;
    byte_s = rd[{a, 3'b000} +: 8];
    half_s = a[1] ? rd[31:16] : rd[15:0];
    case (mtype)
      3'b000:  ld = 32'(byte_s);
      3'b001:  ld = 32'(half_s);
      3'b100:  ld = {24'd0, byte_s};
      3'b101:  ld = {16'd0, half_s};
      default: ld = rd;
    endcase
    return ld;
  endfunction

`ifdef MEM_ALIGN_CHECK_EN
  // Halfword loads need an even address. Word loads, and every code that
  // behaves as a word load, need a word-aligned address.
  function automatic logic misaligned(input logic [2:0] mtype,
                                      input logic [1:0] a);
    logic m;
    case (mtype)
      3'b000, 3'b100: m = 1'b0;
      3'b001, 3'b101: m = a[0];
      default:        m = (a != 2'b00);
    endcase
    return m;
  endfunction
`endif

  assign {gr_we, res_from_mem, mem_type, addr_low2, dest, pc, inst, result} = bus_p0;

  // The stage always finishes in one cycle, so only WB back-pressure stalls it.
  assign allowin = ~mem_valid_p0 | mif.wb_allowin;
  assign accept  = mif.ex_mem_valid & allowin;
  assign leave   = mem_valid_p0 & mif.wb_allowin;

  // Stage occupancy: refreshed from EX whenever the stage can take a new slot.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      mem_valid_p0 <= 1'b0;
    end else if (allowin) begin
      mem_valid_p0 <= mif.ex_mem_valid;
    end
  end

  // EX->MEM bus register: loads only on a real transfer, otherwise holds.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      bus_p0 <= '0;
    end else if (accept) begin
      bus_p0 <= mif.ex_mem_bus;
    end
  end

  // Read-data hold: capture the first-cycle SRAM data when WB stalls us.
  // Drop it on leave or on a new accept, so an incoming instruction uses live data.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      hold_valid_p0 <= 1'b0;
      rdata_hold_p0 <= '0;
    end else if (accept || leave) begin
      hold_valid_p0 <= 1'b0;
    end else if (mem_valid_p0 && !hold_valid_p0 && !mif.wb_allowin) begin
      hold_valid_p0 <= 1'b1;
      rdata_hold_p0 <= mif.data_sram_rdata;
    end
  end

  // ---- MEM stage output: load formatting and result select ----
  assign raw          = hold_valid_p0 ? rdata_hold_p0 : mif.data_sram_rdata;
  assign load_data    = load_extract(raw, mem_type, addr_low2);
  assign final_result = res_from_mem ? load_data : result;

`ifdef MEM_ALIGN_CHECK_EN
  assign ale = mem_valid_p0 & res_from_mem & misaligned(mem_type, addr_low2);
`else
  assign ale = 1'b0;
`endif

  // A register write is only real while the stage holds a valid, well-formed instruction.
  assign wr_en  = mem_valid_p0 & gr_we & ~ale;
  assign wb_bus = {wr_en, dest, pc, inst, final_result};

  assign mif.mem_allowin  = allowin;
  assign mif.mem_wb_valid = mem_valid_p0;
  assign mif.mem_wb_bus   = wb_bus;
  assign mif.mem_id_bus   = {wr_en, dest, final_result};
  assign mif.mem_ale      = ale;

endmodule

// File: tb/tb_mem_stage.sv
// tb_mem_stage: scoreboard bench for mem_stage.
// The driver predicts each accepted instruction's WB/ID outputs from the
// load rules and queues them. The negedge monitor compares queued
// predictions with whatever the stage presents.
module tb_mem_stage;

  typedef struct packed {
    logic [101:0] wb;
    logic [37:0]  id;
    logic         ale;
  } exp_t;

  logic   clk;
  logic   resetn;
  exp_t   q[$];
  bit     occ;
  int     n_cmp;
  int     n_fail;

  mem_stage_if mif ();

  mem_stage dut (
    .clk    (clk),
    .resetn (resetn),
    .mif    (mif)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [101:0] act, input logic [101:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h want %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [107:0] mk(input logic we, input logic rfm, input logic [2:0] mt,
                                      input logic [1:0] a, input logic [4:0] dst,
                                      input logic [31:0] pc, input logic [31:0] inst,
                                      input logic [31:0] res);
    return {we, rfm, mt, a, dst, pc, inst, res};
  endfunction

  // Reference model: loaded value from shifts and masks; misalignment from address arithmetic.
  function automatic exp_t model(input logic [107:0] b, input logic [31:0] rd);
    exp_t        e;
    logic        we, rfm, al;
    logic [2:0]  mt;
    logic [1:0]  a;
    logic [4:0]  dst;
    logic [31:0] pc, inst, res, bv, hv, ld, fr;
    {we, rfm, mt, a, dst, pc, inst, res} = b;
    bv = (rd >> (8 * a)) & 32'h0000_00FF;
    hv = a[1] ? (rd >> 16) : (rd & 32'h0000_FFFF);
    if (mt == 3'd0)      ld = (bv >= 32'h80)   ? (bv | 32'hFFFF_FF00) : bv;
    else if (mt == 3'd1) ld = (hv >= 32'h8000) ? (hv | 32'hFFFF_0000) : hv;
    else if (mt == 3'd4) ld = bv;
    else if (mt == 3'd5) ld = hv;
    else                 ld = rd;
    al = 1'b0;
`ifdef MEM_ALIGN_CHECK_EN
    if (rfm) begin
      if (mt == 3'd1 || mt == 3'd5)      al = (a % 2) != 0;
      else if (mt != 3'd0 && mt != 3'd4) al = (a % 4) != 0;
    end
`endif
    fr    = rfm ? ld : res;
    e.wb  = {we & ~al, dst, pc, inst, fr};
    e.id  = {we & ~al, dst, fr};
    e.ale = al;
    return e;
  endfunction

  // One clock of stimulus. Inputs are applied now and sampled at the next
  // rising edge. Afterwards the SRAM returns rd_instr for an accepted
  // instruction, or rd_idle when nothing was accepted.
  task automatic step(input logic ev, input logic [107:0] b, input logic wa,
                      input logic [31:0] rd_instr, input logic [31:0] rd_idle);
    bit acc, lv;
    mif.ex_mem_valid = ev;
    mif.ex_mem_bus   = b;
    mif.wb_allowin   = wa;
    acc = ev && (!occ || wa);
    lv  = occ && wa;
    @(posedge clk);
    #1;
    if (acc) begin
      q.push_back(model(b, rd_instr));
      occ = 1'b1;
      mif.data_sram_rdata = rd_instr;
    end else begin
      if (lv) occ = 1'b0;
      mif.data_sram_rdata = rd_idle;
    end
  endtask

  // Monitor: compare the stage's outputs against the oldest prediction; retire it when WB takes it.
  always @(negedge clk) begin
    if (resetn) begin
      chk("mem_wb_valid", 102'(mif.mem_wb_valid), 102'(q.size() != 0));
      chk("mem_allowin", 102'(mif.mem_allowin), 102'((q.size() == 0) || mif.wb_allowin));
      if (q.size() != 0) begin
        chk("mem_wb_bus", mif.mem_wb_bus, q[0].wb);
        chk("mem_id_bus", 102'(mif.mem_id_bus), 102'(q[0].id));
        chk("mem_ale", 102'(mif.mem_ale), 102'(q[0].ale));
        if (mif.wb_allowin) void'(q.pop_front());
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [107:0] b;
    n_cmp  = 0;
    n_fail = 0;
    occ    = 1'b0;
    resetn = 1'b0;
    mif.ex_mem_valid    = 1'b0;
    mif.ex_mem_bus      = '0;
    mif.wb_allowin      = 1'b0;
    mif.data_sram_rdata = '0;
    #12;
    chk("rst_wb_valid", 102'(mif.mem_wb_valid), 102'(0));
    chk("rst_allowin", 102'(mif.mem_allowin), 102'(1));
    chk("rst_id_bus", 102'(mif.mem_id_bus), 102'(0));
    chk("rst_ale", 102'(mif.mem_ale), 102'(0));
    @(posedge clk);
    #1 resetn = 1'b1;

    // ALU result passthrough, then back-to-back issue
    step(1'b1, mk(1'b1, 1'b0, 3'd2, 2'd0, 5'd5, 32'h100, 32'h0, 32'h1234_5678), 1'b1, 32'h0, 32'h0);
    #1;
    chk("alu_result", 102'(mif.mem_wb_bus[31:0]), 102'(32'h1234_5678));
    chk("alu_id_bus", 102'(mif.mem_id_bus), 102'({1'b1, 5'd5, 32'h1234_5678}));
    for (int i = 0; i < 4; i++) begin
      step(1'b1, mk(1'b1, 1'b0, 3'd2, 2'd0, 5'(i), 32'(i), 32'h0, 32'(i + 100)), 1'b1, 32'h0, 32'h0);
      #1;
      chk("b2b_result", 102'(mif.mem_wb_bus[31:0]), 102'(i + 100));
    end

    // Byte / half extraction
    step(1'b1, mk(1'b1, 1'b1, 3'd0, 2'd3, 5'd1, 32'h0, 32'h0, 32'h0), 1'b1, 32'h80FF_0000, 32'h0);
    #1 chk("lb_sext", 102'(mif.mem_wb_bus[31:0]), 102'(32'hFFFF_FF80));
    step(1'b1, mk(1'b1, 1'b1, 3'd4, 2'd3, 5'd1, 32'h0, 32'h0, 32'h0), 1'b1, 32'h80FF_0000, 32'h0);
    #1 chk("lbu_zext", 102'(mif.mem_wb_bus[31:0]), 102'(32'h0000_0080));
    step(1'b1, mk(1'b1, 1'b1, 3'd5, 2'd2, 5'd1, 32'h0, 32'h0, 32'h0), 1'b1, 32'h80FF_0000, 32'h0);
    #1 chk("lhu_zext", 102'(mif.mem_wb_bus[31:0]), 102'(32'h0000_80FF));

    // LW stalled by WB for three cycles while the SRAM output drops to zero
    step(1'b1, mk(1'b1, 1'b1, 3'd2, 2'd0, 5'd2, 32'h0, 32'h0, 32'h0), 1'b1, 32'hDEAD_BEEF, 32'h0);
    #1 chk("lw_first", 102'(mif.mem_wb_bus[31:0]), 102'(32'hDEAD_BEEF));
    for (int i = 0; i < 3; i++) begin
      step(1'b0, '0, 1'b0, 32'h0, 32'h0);
      #1;
      chk("lw_hold", 102'(mif.mem_wb_bus[31:0]), 102'(32'hDEAD_BEEF));
      chk("lw_allowin", 102'(mif.mem_allowin), 102'(0));
    end
    // LW leaves while LH enters on the same edge
    step(1'b1, mk(1'b1, 1'b1, 3'd1, 2'd0, 5'd3, 32'h0, 32'h0, 32'h0), 1'b1, 32'h0000_7FFF, 32'h0);
    #1 chk("lh_live", 102'(mif.mem_wb_bus[31:0]), 102'(32'h0000_7FFF));

    // Misaligned LW
    step(1'b1, mk(1'b1, 1'b1, 3'd2, 2'd1, 5'd4, 32'h0, 32'h0, 32'h0), 1'b1, 32'h1111_2222, 32'h0);
    #1;
`ifdef MEM_ALIGN_CHECK_EN
    chk("ale_flag", 102'(mif.mem_ale), 102'(1));
    chk("ale_gr_we", 102'(mif.mem_wb_bus[101]), 102'(0));
    chk("ale_bypass", 102'(mif.mem_id_bus[37]), 102'(0));
`else
    chk("ale_flag", 102'(mif.mem_ale), 102'(0));
    chk("ale_gr_we", 102'(mif.mem_wb_bus[101]), 102'(1));
`endif

    // Asynchronous reset in the middle of a cycle while an instruction sits in MEM
    step(1'b1, mk(1'b1, 1'b0, 3'd2, 2'd0, 5'd7, 32'h0, 32'h0, 32'hCAFE_0001), 1'b1, 32'h0, 32'h0);
    mif.ex_mem_valid = 1'b0;
    mif.wb_allowin   = 1'b0;
    #1;
    resetn = 1'b0;
    q.delete();
    occ = 1'b0;
    #1;
    chk("mid_rst_wb_valid", 102'(mif.mem_wb_valid), 102'(0));
    chk("mid_rst_allowin", 102'(mif.mem_allowin), 102'(1));
    chk("mid_rst_id_bus", 102'(mif.mem_id_bus), 102'(0));
    @(posedge clk);
    #1 resetn = 1'b1;

    // Randomized traffic
    for (int i = 0; i < 600; i++) begin
      b = {$urandom, $urandom, $urandom, $urandom};
      step(($urandom_range(0, 9) < 7), b, ($urandom_range(0, 9) < 6), $urandom, $urandom);
    end

    // Drain
    for (int i = 0; i < 3; i++) step(1'b0, '0, 1'b1, 32'h0, 32'h0);
    chk("drain_empty", 102'(q.size()), 102'(0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
